// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // A programmed width of 0 still produces a single-cycle pulse.
    function automatic logic [31:0] clamp_width(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] w_idx;

    // Walk the request vector starting at ptr; the first hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_idx      = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IW'((int'(ptr) + k) % N);
            if (!any && req[w_idx]) begin
                any               = 1'b1;
                gnt_idx           = w_idx;
                gnt_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one one-shot pulse between N_REQ edge-triggered requesters, round-robin.
// Latency: trigger sampled at edge k -> pending at k -> pulse high from k+1 for W cycles.
// Backpressure: none; a second edge on an already-pending requester is dropped and flagged.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH_W = 8,
    parameter int GAP     = 2
) (
    input  logic                     clk,
    input  logic                     async_reset_n,
    input  logic [N_REQ-1:0]         trigger,
    input  logic [WIDTH_W-1:0]       pulse_width,
    output logic                     pulse,
    output logic [$clog2(N_REQ)-1:0] pulse_id,
    output logic                     busy,
    output logic [N_REQ-1:0]         pending,
    output logic [N_REQ-1:0]         drop
);

    localparam int IW = $clog2(N_REQ);
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    logic [N_REQ-1:0]   r_trig_q;
    logic [N_REQ-1:0]   r_pending;
    logic [N_REQ-1:0]   r_drop;
    state_t             r_state;
    logic [WIDTH_W-1:0] r_cnt;
    logic [GW-1:0]      r_gcnt;
    logic               r_pulse;
    logic [IW-1:0]      r_pulse_id;
    logic [IW-1:0]      r_rr_ptr;

    logic [N_REQ-1:0]   w_edge;
    logic [N_REQ-1:0]   w_clear;
    logic [N_REQ-1:0]   w_gnt_onehot;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_any;
    state_t             w_state_nxt;
    logic [WIDTH_W-1:0] w_cnt_nxt;
    logic [GW-1:0]      w_gcnt_nxt;
    logic               w_pulse_nxt;
    logic [IW-1:0]      w_id_nxt;
    logic [IW-1:0]      w_ptr_nxt;

    assign w_edge = trigger & ~r_trig_q;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req        (r_pending),
        .ptr        (r_rr_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // Edge history and pending set; a fresh edge beats a same-cycle grant clear.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_trig_q  <= '0;
            r_pending <= '0;
            r_drop    <= '0;
        end else begin
            r_trig_q  <= trigger;
            r_pending <= w_edge | (r_pending & ~w_clear);
            r_drop    <= w_edge & r_pending & ~w_clear;
        end
    end

    // Next-state and datapath: grant in IDLE, count width in PULSE, holdoff in GAP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_pulse_nxt = r_pulse;
        w_id_nxt    = r_pulse_id;
        w_ptr_nxt   = r_rr_ptr;
        w_clear     = '0;
        case (r_state)
            S_IDLE: begin
                w_pulse_nxt = 1'b0;
                if (w_any) begin
                    w_clear     = w_gnt_onehot;
                    w_cnt_nxt   = WIDTH_W'(clamp_width(32'(pulse_width)));
                    w_id_nxt    = w_gnt_idx;
                    w_pulse_nxt = 1'b1;
                    w_ptr_nxt   = (w_gnt_idx == IW'(N_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (r_cnt == WIDTH_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b0;
                    if (GAP == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_gcnt_nxt  = GW'(GAP);
                        w_state_nxt = S_GAP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - WIDTH_W'(1);
                end
            end
            S_GAP: begin
                w_pulse_nxt = 1'b0;
                if (r_gcnt == GW'(1)) begin
                    w_gcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt - GW'(1);
                end
            end
            default: begin
                w_pulse_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and pulse registers; reset kills any pulse in flight.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_gcnt     <= '0;
            r_pulse    <= 1'b0;
            r_pulse_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gcnt     <= w_gcnt_nxt;
            r_pulse    <= w_pulse_nxt;
            r_pulse_id <= w_id_nxt;
            r_rr_ptr   <= w_ptr_nxt;
        end
    end

    assign pulse    = r_pulse;
    assign pulse_id = r_pulse_id;
    assign busy     = (r_state != S_IDLE);
    assign pending  = r_pending;
    assign drop     = r_drop;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: directed triggers, pulses checked by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_pulse_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] trigger;
    logic [7:0] pulse_width;
    logic       pulse;
    logic [1:0] pulse_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] drop;

    pulse_scheduler #(.N_REQ(4), .WIDTH_W(8), .GAP(2)) dut (
        .clk           (clk),
        .async_reset_n (rst_n),
        .trigger       (trigger),
        .pulse_width   (pulse_width),
        .pulse         (pulse),
        .pulse_id      (pulse_id),
        .busy          (busy),
        .pending       (pending),
        .drop          (drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pulse: owner id, width (-1 = don't care), rise cycle and preceding low gap (-1 = don't care).
    typedef struct {
        int id;
        int width;
        int start;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || pending != 4'd0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", t);
        end
        repeat (3) tick();
    endtask

    // Monitor: match every observed pulse against the head of the scoreboard.
    initial begin
        logic prev;
        bit   have;
        int   rise_cyc;
        int   fall_cyc;
        exp_t cur;
        prev     = 1'b0;
        have     = 1'b0;
        rise_cyc = 0;
        fall_cyc = -1;
        cur      = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (pulse && !prev) begin
                rise_cyc = cyc;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: id %0d at cycle %0d, expected no pulse", pulse_id, cyc);
                    have = 1'b0;
                end else begin
                    cur  = sb.pop_front();
                    have = 1'b1;
                    check("pulse_id", int'(pulse_id), cur.id);
                    if (cur.start >= 0) check("pulse_start", rise_cyc, cur.start);
                    if (cur.gap >= 0)   check("low_gap", rise_cyc - fall_cyc, cur.gap);
                end
            end
            if (!pulse && prev) begin
                fall_cyc = cyc;
                if (have && cur.width >= 0) check("pulse_width", cyc - rise_cyc, cur.width);
                have = 1'b0;
            end
            prev = pulse;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int nb;
        rst_n       = 1'b0;
        trigger     = 4'd0;
        pulse_width = 8'd3;
        repeat (3) @(posedge clk);
        #2;
        check("rst_pulse", int'(pulse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_drop", int'(drop), 0);
        check("rst_pulse_id", int'(pulse_id), 0);
        rst_n = 1'b1;

        // 1: single edge on req 0, width 3.
        tick();
        c = cyc;
        sb.push_back('{0, 3, c + 2, -1});
        trigger = 4'b0001;
        tick();
        trigger = 4'b0000;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("t1_busy_cycles", nb, 5);

        // 2: simultaneous edges on 1,2,3, width 1; served 1,2,3 with 3 low cycles between.
        wait_idle();
        pulse_width = 8'd1;
        c = cyc;
        sb.push_back('{1, 1, c + 2, -1});
        sb.push_back('{2, 1, c + 6, 3});
        sb.push_back('{3, 1, c + 10, 3});
        trigger = 4'b1110;
        tick();
        trigger = 4'b0000;
        at_cyc(c + 1);  check("t2_pending_a", int'(pending), 4'b1110);
        at_cyc(c + 2);  check("t2_pending_b", int'(pending), 4'b1100);
        at_cyc(c + 6);  check("t2_pending_c", int'(pending), 4'b1000);
        at_cyc(c + 10); check("t2_pending_d", int'(pending), 4'b0000);

        // 3: after req 3 wins, edges on 0 and 3 -> pointer wrapped, 0 served first.
        tick();
        c = cyc;
        sb.push_back('{0, 1, c + 3, 3});
        sb.push_back('{3, 1, c + 7, 3});
        trigger = 4'b1001;
        tick();
        trigger = 4'b0000;
        at_cyc(c + 1);  check("t3_pending", int'(pending), 4'b1001);

        // 4: second edge on still-pending req 2 is dropped.
        wait_idle();
        pulse_width = 8'd2;
        c = cyc;
        sb.push_back('{1, 2, c + 2, -1});
        sb.push_back('{2, 2, c + 7, 3});
        trigger = 4'b0110;
        tick();
        trigger = 4'b0000;
        tick();
        trigger = 4'b0100;
        tick();
        trigger = 4'b0000;
        at_cyc(c + 3);
        check("t4_drop_hi", int'(drop), 4'b0100);
        check("t4_pending", int'(pending), 4'b0100);
        at_cyc(c + 4);
        check("t4_drop_lo", int'(drop), 0);

        // 5: reset mid-pulse with another request pending.
        wait_idle();
        pulse_width = 8'd8;
        c = cyc;
        sb.push_back('{0, -1, c + 2, -1});
        trigger = 4'b0001;
        tick();
        trigger = 4'b0000;
        repeat (3) tick();
        trigger = 4'b0010;
        tick();
        trigger = 4'b0000;
        check("t5_pulse_before", int'(pulse), 1);
        check("t5_pending_before", int'(pending), 4'b0010);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_pulse", int'(pulse), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_pending", int'(pending), 0);
        #1 rst_n = 1'b1;
        repeat (25) tick();
        check("t5_after_busy", int'(busy), 0);
        check("t5_after_pending", int'(pending), 0);

        // 6: width 0 -> 1 cycle; trigger held high for 20 cycles -> single pulse.
        pulse_width = 8'd0;
        c = cyc;
        sb.push_back('{2, 1, c + 2, -1});
        trigger = 4'b0100;
        repeat (20) tick();
        trigger = 4'b0000;
        wait_idle();
        repeat (5) tick();

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
